// File: rtl/reg_arbiter.sv
// rtl/reg_arbiter.sv - round-robin arbiter feeding a single output holding register
//
// Purpose: N_REQ requesters compete for one W-bit holding register. The grant
// scans req_valid upward from a rotating pointer, so the requester after the
// last winner has the highest priority. The held word is offered downstream
// with a valid/ready handshake, and completed handshakes are counted.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   req_valid  [N_REQ]    per-requester valid
//   req_data   [N_REQ*W]  packed request data, requester i at [i*W +: W]
//   req_ready  [N_REQ]    combinational accept strobe, at most one bit set
//   out_valid             holding register contains a word
//   out_data   [W]        holding register data
//   out_src    [SW]       index of the requester that supplied out_data
//   out_ready             downstream accepts the word
//   xfer_cnt   [16]       saturating count of output handshakes
module reg_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  localparam int SW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_data,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready,
  output logic [15:0]        xfer_cnt
);

  logic [SW-1:0] ptr;
  logic [SW-1:0] grant;
  logic          any_req;
  logic          load_en;
  logic          xfer;
  logic [W-1:0]  win_data;
  logic [SW-1:0] ptr_next;

  // The register may take a new word when it is empty or being drained now.
  assign load_en = !out_valid || out_ready;
  assign xfer    = load_en && !rst && any_req;

  // Rotating priority scan: offset k from ptr, wrapped modulo N_REQ.
  always_comb begin
    int            idx;
    logic [SW-1:0] idx_s;
    grant   = '0;
    any_req = 1'b0;
    idx     = 0;
    idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_s = idx[SW-1:0];
      if (!any_req && req_valid[idx_s]) begin
        any_req = 1'b1;
        grant   = idx_s;
      end
    end
  end

  // Data mux and ready strobes decoded from the grant index with constant
  // selects; req_ready deliberately ignores req_data.
  always_comb begin
    win_data  = '0;
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == SW'(i)) begin
        win_data     = req_data[i*W +: W];
        req_ready[i] = xfer;
      end
    end
  end

  assign ptr_next = (grant == SW'(N_REQ - 1)) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      ptr       <= '0;
      xfer_cnt  <= '0;
    end else begin
      if (out_valid && out_ready && xfer_cnt != 16'hFFFF)
        xfer_cnt <= xfer_cnt + 16'd1;
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_src   <= grant;
        ptr       <= ptr_next;
      end else if (load_en) begin
        // Drained with nothing to refill: data and source keep last values.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_reg_arbiter.sv
// tb/tb_reg_arbiter.sv - self-checking bench for reg_arbiter with a behavioural model
//
// Purpose: drives directed scenarios and randomized traffic into reg_arbiter
// (N_REQ=4, W=8) and compares every output against a cycle-level model
// computed from the arbitration rules with plain integer arithmetic.
// Ports: none (top-level bench).
module tb_reg_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        out_ready = 1'b0;
  logic [15:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Model state
  bit   m_valid = 0;
  int   m_data  = 0;
  int   m_src   = 0;
  int   m_ptr   = 0;
  int   m_cnt   = 0;
  logic [3:0] rdy_seen;
  logic [3:0] exp_ready;

  always #5 clk = ~clk;

  reg_arbiter #(.N_REQ(4), .W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  // Drive one cycle of inputs, sample req_ready mid-cycle, advance the model
  // and the clock. Returns #1 after the rising edge.
  task automatic step(input logic [3:0] v, input logic [31:0] d,
                      input logic ordy, input logic r);
    int  g;
    bit  any;
    bit  le;
    bit  take;
    req_valid = v; req_data = d; out_ready = ordy; rst = r;
    #1;
    rdy_seen = req_ready;
    le = !m_valid || ordy;
    any = 0; g = 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (!any && v[i]) begin any = 1; g = i; end
    end
    take = !r && le && any;
    exp_ready = take ? 4'(1 << g) : 4'b0;
    if (r) begin
      m_valid = 0; m_data = 0; m_src = 0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (m_valid && ordy && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (take) begin
        m_valid = 1; m_data = int'(d[g*8 +: 8]); m_src = g; m_ptr = (g + 1) % 4;
      end else if (le) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(4'hF, 32'h13121110, 1'b1, 1'b1);
    checks++; if (rdy_seen !== 4'b0) begin errors++; $display("FAIL reset_ready: got %b want 0000", rdy_seen); end
    step(4'hF, 32'h13121110, 1'b1, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", out_src); end
    checks++; if (xfer_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", xfer_cnt); end
  endtask

  task automatic test_round_robin();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    int exp_dat[5] = '{'h10, 'h11, 'h12, 'h13, 'h10};
    for (int i = 0; i < 5; i++) begin
      step(4'hF, 32'h13121110, 1'b1, 1'b0);
      checks++; if (rdy_seen !== 4'(1 << exp_src[i])) begin errors++; $display("FAIL rr_ready[%0d]: got %b want %b", i, rdy_seen, 4'(1 << exp_src[i])); end
      checks++; if (out_valid !== 1'b1 || out_src !== 2'(exp_src[i]) || out_data !== 8'(exp_dat[i])) begin
        errors++; $display("FAIL rr_out[%0d]: got v=%b src=%0d data=%h want v=1 src=%0d data=%h", i, out_valid, out_src, out_data, exp_src[i], exp_dat[i]);
      end
    end
    checks++; if (xfer_cnt !== 16'd4) begin errors++; $display("FAIL rr_cnt: got %0d want 4", xfer_cnt); end
  endtask

  task automatic test_fairness();
    int exp_src[4] = '{1, 3, 1, 3};
    step(4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(4'b1010, $urandom, 1'b1, 1'b0);
      checks++; if (rdy_seen[0] !== 1'b0 || rdy_seen[2] !== 1'b0) begin errors++; $display("FAIL fair_ready[%0d]: got %b want bits 0,2 clear", i, rdy_seen); end
      checks++; if (out_src !== 2'(exp_src[i])) begin errors++; $display("FAIL fair_src[%0d]: got %0d want %0d", i, out_src, exp_src[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] cnt0;
    step(4'h0, 32'h0, 1'b0, 1'b1);
    step(4'b0100, 32'h00A50000, 1'b1, 1'b0);
    cnt0 = xfer_cnt;
    for (int i = 0; i < 5; i++) begin
      step(4'hF, $urandom, 1'b0, 1'b0);
      checks++; if (rdy_seen !== 4'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, rdy_seen); end
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_src !== 2'd2 || xfer_cnt !== cnt0) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b data=%h src=%0d cnt=%0d want v=1 data=a5 src=2 cnt=%0d", i, out_valid, out_data, out_src, xfer_cnt, cnt0);
      end
    end
    // Pointer must still be 3 after the stall.
    step(4'hF, 32'h44332211, 1'b1, 1'b0);
    checks++; if (out_src !== 2'd3 || out_data !== 8'h44) begin errors++; $display("FAIL bp_ptr: got src=%0d data=%h want src=3 data=44", out_src, out_data); end
  endtask

  task automatic test_drain();
    step(4'h0, 32'h0, 1'b0, 1'b1);
    step(4'b0001, 32'h0000005A, 1'b1, 1'b0);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    checks++; if (xfer_cnt !== 16'd1) begin errors++; $display("FAIL drain_cnt: got %0d want 1", xfer_cnt); end
    checks++; if (out_data !== 8'h5A || out_src !== 2'd0) begin errors++; $display("FAIL drain_keep: got data=%h src=%0d want data=5a src=0", out_data, out_src); end
  endtask

  task automatic test_reset_mid();
    step(4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1100, 32'h77660000, 1'b1, 1'b0);
    step(4'hF, 32'h0, 1'b0, 1'b0);
    step(4'hF, 32'h0, 1'b0, 1'b1);
    checks++; if (out_valid !== 1'b0 || xfer_cnt !== 16'd0) begin errors++; $display("FAIL midrst: got v=%b cnt=%0d want v=0 cnt=0", out_valid, xfer_cnt); end
    step(4'hF, 32'hDDCCBBAA, 1'b1, 1'b0);
    checks++; if (out_src !== 2'd0 || out_data !== 8'hAA) begin errors++; $display("FAIL midrst_grant: got src=%0d data=%h want src=0 data=aa", out_src, out_data); end
  endtask

  task automatic test_random();
    step(4'h0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [3:0] v;
      v = 4'($urandom);
      if ($urandom_range(0, 3) == 0) v = 4'(1 << $urandom_range(0, 3));
      step(v, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0));
      checks++;
      if (rdy_seen !== exp_ready || out_valid !== 1'(m_valid) || out_data !== 8'(m_data) ||
          out_src !== 2'(m_src) || xfer_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL rand[%0d]: got rdy=%b v=%b d=%h s=%0d c=%0d want rdy=%b v=%b d=%h s=%0d c=%0d",
                 i, rdy_seen, out_valid, out_data, out_src, xfer_cnt, exp_ready, m_valid, 8'(m_data), m_src, m_cnt);
      end
    end
  endtask

  task automatic test_saturation();
    step(4'h0, 32'h0, 1'b0, 1'b1);
    req_valid = 4'hF; out_ready = 1'b1; rst = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    checks++; if (xfer_cnt !== 16'd999) begin errors++; $display("FAIL sat_mid: got %0d want 999", xfer_cnt); end
    repeat (65535 + 3 - 999 + 5) @(posedge clk);
    #1;
    checks++; if (xfer_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_cap: got %h want ffff", xfer_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (xfer_cnt !== 16'hFFFF || out_valid !== 1'b1) begin errors++; $display("FAIL sat_hold: got cnt=%h v=%b want cnt=ffff v=1", xfer_cnt, out_valid); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_backpressure();
    test_drain();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
